// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 driver and its stream loader: FSM encoding,
// per-LED byte layout and a width helper.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int BYTES_PER_LED = 3;
  localparam int BITS_PER_LED  = 24;

  // Byte lane of each colour inside a 24-bit LED word {G, R, B}.
  localparam int CH_G = 2;
  localparam int CH_R = 1;
  localparam int CH_B = 0;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_byte_scale.sv
// Brightness scaler: o_data = (i_data * (i_scale + 1)) >> 8, so a scale of 255
// passes the byte through unchanged and a scale of 0 yields 0.
module ws2812_byte_scale (
  input  logic [7:0] i_data,
  input  logic [7:0] i_scale,
  output logic [7:0] o_data
);

  logic [15:0] w_factor;
  logic [15:0] w_product;

  // 255 * 256 still fits in 16 bits, so the product never overflows.
  assign w_factor  = 16'(i_scale) + 16'd1;
  assign w_product = 16'(i_data) * w_factor;
  assign o_data    = 8'(w_product >> 8);

endmodule

// File: rtl/ws2812_stream_loader.sv
// Assembles a G,R,B byte stream into a shadow frame and commits it atomically
// to packed_rgb_data. Define WS2812_LOADER_BRIGHTNESS_EN to add brightness scaling.
module ws2812_stream_loader
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS       = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
`ifdef WS2812_LOADER_BRIGHTNESS_EN
  input  logic [7:0]                       brightness,
`endif
  output logic                             in_ready,
  output logic [BITS_PER_LED*NUM_LEDS-1:0] packed_rgb_data,
  output logic                             frame_commit,
  output logic                             busy
);

  localparam int FRAME_W = BITS_PER_LED * NUM_LEDS;
  localparam int LED_W   = clog2_min1(NUM_LEDS);
  localparam int TO_W    = clog2_min1(TIMEOUT_CYCLES);

  localparam logic [LED_W-1:0] LAST_LED  = LED_W'(NUM_LEDS - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_LED - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_ready_en;
  logic [LED_W-1:0]   r_led_cnt;
  logic [1:0]         r_byte_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [FRAME_W-1:0] r_shadow;
  logic [FRAME_W-1:0] r_packed;
  logic               r_commit;

  logic               w_accept;
  logic               w_last_byte;
  logic               w_timeout;
  logic [7:0]         w_byte;

`ifdef WS2812_LOADER_BRIGHTNESS_EN
  ws2812_byte_scale u_scale (
    .i_data  (in_data),
    .i_scale (brightness),
    .o_data  (w_byte)
  );
`else
  assign w_byte = in_data;
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_last_byte = (r_led_cnt == LAST_LED) && (r_byte_cnt == LAST_BYTE);
  // An accepted byte on the firing cycle takes priority over the timeout.
  assign w_timeout   = (r_state == ST_LOAD) && !w_accept && (r_to_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the next-state default is assigned first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_LOAD;
      ST_LOAD: begin
        if (w_accept && w_last_byte) w_next_state = ST_COMMIT;
        else if (w_timeout)          w_next_state = ST_IDLE;
      end
      ST_COMMIT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // in_ready stays low in the first cycle after reset release via r_ready_en.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      ST_IDLE:   in_ready = r_ready_en;
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_en <= 1'b0;
      r_led_cnt  <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_ready_en <= 1'b1;

      if (r_state == ST_COMMIT || w_timeout) begin
        r_led_cnt  <= '0;
        r_byte_cnt <= '0;
      end else if (w_accept) begin
        if (r_byte_cnt == LAST_BYTE) begin
          r_byte_cnt <= '0;
          r_led_cnt  <= w_last_byte ? '0 : r_led_cnt + LED_W'(1);
        end else begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end

      if (r_state != ST_LOAD || w_accept || w_timeout) r_to_cnt <= '0;
      else                                             r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // NOTE: the shadow frame is flop-based and explicitly reset, so a reset
  // mid-frame leaves no stale bytes behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_packed <= '0;
      r_commit <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        for (int b = 0; b < BYTES_PER_LED; b++) begin
          if (w_accept && r_led_cnt == LED_W'(i) && r_byte_cnt == 2'(b))
            r_shadow[i*BITS_PER_LED + 8*(CH_G-b) +: 8] <= w_byte;
        end
      end
      if (r_state == ST_COMMIT) r_packed <= r_shadow;
      r_commit <= (r_state == ST_COMMIT);
    end
  end

  assign packed_rgb_data = r_packed;
  assign frame_commit    = r_commit;

endmodule
